mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide unit for the single-cycle MIPS-style datapath; sits directly
//   downstream of the register file, consuming ReadData1 (rs) / ReadData2 (rt) and producing
//   HI/LO, which feed the WriteData mux for MFHI/MFLO. Shift-add multiply, restoring divide,
//   one bit per clk; control holds the pipeline on busy.
// PARAMETERS
//   WIDTH   32   operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//   clk          in   1        clock; all state updates on posedge clk
//   reset        in   1        synchronous, active-high reset
//   start        in   1        request; sampled only when busy==0
//   op           in   2        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   ReadData1    in   WIDTH    operand A (rs): multiplicand / dividend
//   ReadData2    in   WIDTH    operand B (rt): multiplier / divisor
//   busy         out  1        high while an operation is in flight
//   done         out  1        one-cycle pulse: HI/LO/div_by_zero just updated
//   HI           out  WIDTH    MULT: upper product; DIV: remainder
//   LO           out  WIDTH    MULT: lower product; DIV: quotient
//   div_by_zero  out  1        set with done when a DIV/DIVU had B==0; else cleared with done
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, HI=0, LO=0, div_by_zero=0. Reset mid-operation aborts
//     it; HI/LO are cleared, no done pulse.
//   States: IDLE -> RUN (start && !busy) ; RUN -> FIX after WIDTH iterations ; FIX -> IDLE.
//   busy = (state != IDLE), combinational from state.
//   Edge E0 (start seen in IDLE): latch op, latch |A|, |B| (magnitudes for signed ops,
//     raw for unsigned), result signs: sign_q = A[W-1]^B[W-1], sign_r = A[W-1]; count=0.
//   Edges E1..E32: one iteration each; count increments, wraps to FIX at count==WIDTH-1.
//   Multiply: if multiplier LSB, add multiplicand into upper accumulator; shift 2*WIDTH
//     accumulator right one bit, carry into MSB.
//   Divide: shift {rem,quo} left one; if rem >= divisor subtract and set quo LSB.
//   Edge E33 (FIX): apply signs (two's-complement negate product if sign_q for MULT;
//     quotient if sign_q, remainder if sign_r for DIV); write HI/LO; done=1 for one cycle.
//   Latency: done high in the cycle following E33, i.e. 34 clk after the start cycle.
//   HI/LO hold value between operations; unchanged during RUN (internal accumulators only).
//   start while busy: ignored, no queueing. start in the done cycle: accepted (state IDLE).
//   op value sampled only at E0; later op changes have no effect.
//   Divide by zero (B==0): still runs full latency; result forced to LO=all ones,
//     HI=A (original, unsigned view), div_by_zero=1.
//   DIV overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0, div_by_zero=0.
//   Product width: full 2*WIDTH bits, no truncation; sign fix over full 64 bits.
// TESTING
//   MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done at cycle 34; HI=0xFFFFFFFE LO=0x00000001.
//   MULT A=0xFFFFFFFD(-3) B=7 -> HI=0xFFFFFFFF LO=0xFFFFFFEB (-21); busy high 33 cycles.
//   DIV A=-7 B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=100 B=7 -> LO=14 HI=2.
//   DIVU A=0x12345678 B=0 -> LO=0xFFFFFFFF HI=0x12345678 div_by_zero=1; next MULTU clears it.
//   start pulsed at cycle 10 of a run with new operands -> ignored, result of first op only;
//     start in done cycle -> second op's done exactly 34 cycles later.
//   reset asserted at iteration 16 -> busy=0, HI=LO=0 next cycle, no done pulse.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per clock.
// HI/LO are written once per operation, in the sign-fix cycle after the last iteration.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [CW-1:0]    count_q,   count_d;
  logic             is_div_q,  is_div_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic             dbz_q,     dbz_d;
  logic [WIDTH-1:0] opb_q,     opb_d;
  logic [WIDTH-1:0] hacc_q,    hacc_d;
  logic [WIDTH-1:0] lacc_q,    lacc_d;
  logic             done_q,    done_d;
  logic             dbzo_q,    dbzo_d;
  logic [WIDTH-1:0] hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;

  logic             a_neg, b_neg, rem_ge;
  logic [WIDTH-1:0] a_mag, b_mag, rem_diff;
  logic [WIDTH:0]   rem_s, sum;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign div_by_zero = dbzo_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    dbz_d     = dbz_q;
    opb_d     = opb_q;
    hacc_d    = hacc_q;
    lacc_d    = lacc_q;
    done_d    = 1'b0;
    dbzo_d    = dbzo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    // Operand magnitudes (signed ops only) and per-iteration datapath values
    a_neg    = op[0] & ReadData1[WIDTH-1];
    b_neg    = op[0] & ReadData2[WIDTH-1];
    a_mag    = a_neg ? -ReadData1 : ReadData1;
    b_mag    = b_neg ? -ReadData2 : ReadData2;
    rem_s    = {hacc_q, lacc_q[WIDTH-1]};
    rem_ge   = (rem_s >= {1'b0, opb_q});
    rem_diff = rem_s[WIDTH-1:0] - opb_q;
    sum      = {1'b0, hacc_q} + (lacc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
    prod     = {hacc_q, lacc_q};
    prod_neg = -prod;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          count_d   = '0;
          is_div_d  = op[1];
          sgn_quo_d = a_neg ^ b_neg;
          sgn_rem_d = a_neg;
          dbz_d     = op[1] & (ReadData2 == '0);
          hacc_d    = '0;
          opb_d     = op[1] ? b_mag : a_mag;
          lacc_d    = op[1] ? a_mag : b_mag;
        end
      end
      RUN: begin
        if (is_div_q) begin
          hacc_d = rem_ge ? rem_diff : rem_s[WIDTH-1:0];
          lacc_d = {lacc_q[WIDTH-2:0], rem_ge};
        end else begin
          {hacc_d, lacc_d} = {sum, lacc_q[WIDTH-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = FIX;
      end
      FIX: begin
        // Quotient is forced to all ones on divide-by-zero; the remainder already equals A
        if (is_div_q) begin
          lo_d = dbz_q ? '1 : (sgn_quo_q ? -lacc_q : lacc_q);
          hi_d = sgn_rem_q ? -hacc_q : hacc_q;
        end else begin
          {hi_d, lo_d} = sgn_quo_q ? prod_neg : prod;
        end
        dbzo_d  = dbz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      opb_q     <= '0;
      hacc_q    <= '0;
      lacc_q    <= '0;
      done_q    <= 1'b0;
      dbzo_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      dbz_q     <= dbz_d;
      opb_q     <= opb_d;
      hacc_q    <= hacc_d;
      lacc_q    <= lacc_d;
      done_q    <= done_d;
      dbzo_q    <= dbzo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random operations against an
// arithmetic reference model (64-bit products, truncating signed division).
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rd1, rd2;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .ReadData1(rd1), .ReadData2(rd2),
    .busy(busy), .done(done), .HI(hi), .LO(lo), .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ed = 1'b0;
    case (o)
      2'd0: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      2'd1: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF; eh = a; ed = 1'b1;
        end else if (o == 2'd2) begin
          el = a / b; eh = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          el = 32'(q); eh = 32'(r);
        end
      end
    endcase
  endtask

  // Issue one operation (called at #1 after an edge) and check latency, busy, hold and result
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [31:0] eh, el, h0, l0;
    logic ed;
    int n, bcnt;
    bit seen, hold_ok;
    model(o, a, b, eh, el, ed);
    h0 = hi; l0 = lo; hold_ok = 1'b1;
    start = 1'b1; op = o; rd1 = a; rd2 = b;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); rd1 = $urandom; rd2 = $urandom;
    bcnt = busy ? 1 : 0;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      start = (poke && n == 9);
      if (start) begin op = 2'($urandom); rd1 = $urandom; rd2 = $urandom_range(1, 9); end
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
      else begin
        if (busy) bcnt++;
        if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "/latency"}, 64'(n), 64'd33);
    check({tag, "/busy_cycles"}, 64'(bcnt), 64'd33);
    check({tag, "/hold"}, 64'(hold_ok), 64'd1);
    check({tag, "/HI"}, 64'(hi), 64'(eh));
    check({tag, "/LO"}, 64'(lo), 64'(el));
    check({tag, "/dbz"}, 64'(dbz), 64'(ed));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit got_done;

    reset = 1'b1; start = 1'b0; op = 2'd0; rd1 = '0; rd2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/HI", 64'(hi), 64'd0);
    check("reset/LO", 64'(lo), 64'd0);
    check("reset/dbz", 64'(dbz), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases; back-to-back calls start in the done cycle
    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max/HI_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max/LO_const", 64'(lo), 64'h0000_0000_0000_0001);
    run_op("mult_neg3x7", 2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg3x7/LO_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
    run_op("div_neg7by2", 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg7by2/LO_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    run_op("divu_100by7", 2'd2, 32'd100, 32'd7, 1'b0);
    check("divu_100by7/HI_const", 64'(hi), 64'd2);
    run_op("divu_by0", 2'd2, 32'h1234_5678, 32'd0, 1'b0);
    check("divu_by0/dbz_const", 64'(dbz), 64'd1);
    run_op("multu_clr", 2'd0, 32'd12345, 32'd678, 1'b0);
    run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf/LO_const", 64'(lo), 64'h0000_0000_8000_0000);
    run_op("div_by0_neg", 2'd3, 32'h8765_4321, 32'd0, 1'b0);
    run_op("mult_minmin", 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("ignored_start", 2'd1, 32'hFFFF_FF00, 32'h0001_0001, 1'b1);

    // Reset at iteration 16 aborts the operation with no done pulse
    start = 1'b1; op = 2'd0; rd1 = 32'hDEAD_BEEF; rd2 = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset/busy", 64'(busy), 64'd0);
    check("midreset/HI", 64'(hi), 64'd0);
    check("midreset/LO", 64'(lo), 64'd0);
    check("midreset/done", 64'(done), 64'd0);
    got_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) got_done = 1'b1;
    end
    check("midreset/no_done", 64'(got_done), 64'd0);

    // Random operations with biased divisors
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
